uart_tx_framer: RTL
===================

# uart_tx_framer

Parametrised UART transmit framer that turns a parallel word into a serial frame: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity, and 1 or 2 stop bits. It combines serializer, parity generator, frame FSM and registered line driver in one block, and drives the TX pin directly. Frame format is selected at run time and latched per frame. Bit timing comes from an external baud-enable strobe. Back-to-back frames are sent with no idle gap.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  asynchronous, active-low reset
- Baud_En  in  1  bit-rate strobe; the FSM and TX_Out advance only on CLK edges where Baud_En=1; tie high for one bit per clock
- P_DATA  in  DATA_WIDTH  parallel word, sampled at acceptance
- Data_Valid  in  1  transmit request (level); held until Data_Ack
- PAR_EN  in  1  1 = parity bit present; sampled at acceptance
- PAR_TYP  in  1  0 = even, 1 = odd; sampled at acceptance
- STOP2  in  1  0 = one stop bit, 1 = two; sampled at acceptance
- TX_Out  out  1  serial line, registered; idle high
- Busy  out  1  registered; 1 while a frame is on the line
- Data_Ack  out  1  registered one-cycle pulse on the acceptance edge

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when the latched PAR_EN=0.
- Acceptance edge: Baud_En=1, Data_Valid=1, and either:
  - state=IDLE, or
  - state=STOP on its final stop bit.
- On the acceptance edge:
  - capture P_DATA, PAR_EN, PAR_TYP and STOP2;
  - TX_Out<=0 (start bit), Busy<=1, Data_Ack<=1;
  - state goes to DATA with the bit counter at 0.
- Changes to inputs after acceptance have no effect on the frame in flight.
- DATA: on each tick TX_Out<=data[cnt] and cnt increments. After bit DATA_WIDTH-1, go to PARITY or STOP.
  - The counter is $clog2(DATA_WIDTH) bits wide, with no wrap inside a frame.
- Parity bit:
  - even: XOR-reduce of the captured data;
  - odd: the inverted XOR-reduce;
  - computed from the captured register, not from P_DATA.
- STOP: TX_Out<=1 for one or two ticks.
  - On the tick after the last stop bit: if an acceptance condition holds, start the next frame; otherwise go to IDLE and set Busy<=0.
- Data_Valid=1 on a non-tick edge is not accepted; it waits for the next tick.
- Data_Valid dropped before acceptance: no frame is sent and no state changes.

## Timing
- Reset values, applied asynchronously on RST=0: TX_Out=1, Busy=0, Data_Ack=0, state=IDLE, counter=0, captured registers=0.
- Reset mid-frame aborts at once. The line returns high with no partial stop bit, and nothing resumes after release.
- Frame length F = 1 + DATA_WIDTH + PAR_EN + (1 + STOP2) ticks.
- Tick numbering: acceptance tick = t0; start bit on line from t0.
  - data bit i from t(1+i);
  - parity at t(1+DATA_WIDTH);
  - stop bits follow;
  - next start bit, or Busy=0, at t(F).
- Between ticks, all outputs hold, except Data_Ack, which is high only for the CLK cycle after the acceptance edge.
- Back-to-back: with Data_Valid held high, frames are contiguous, Busy never drops, and Data_Ack pulses every F ticks.
- Latency from Data_Valid to the start bit on the line: 0 cycles after the first tick edge that sees Data_Valid=1.

## Test plan
1. Hold RST=0 mid-run, Baud_En=1 → TX_Out=1, Busy=0 and Data_Ack=0 immediately (asynchronous); after release, the line stays 1 with no request.
2. Baud_En=1, DATA_WIDTH=8, P_DATA=8'hA5, PAR_EN=0, STOP2=0 → Data_Ack one cycle at t0; TX_Out for t0..t9 = 0,1,0,1,0,0,1,0,1,1; Busy=0 at t10.
3. P_DATA=8'h07, PAR_EN=1, PAR_TYP=0 → parity bit at t9 = 1. Repeat with PAR_TYP=1 → parity bit = 0. Frame length 11.
4. Data_Valid held, STOP2=1, PAR_EN=0; P_DATA=8'h00, then 8'hFF after the first Data_Ack → second start bit at t11, Busy high throughout, Data_Ack at t0 and t11, stop bits high at t9 and t10.
5. Baud_En high every 4th cycle; Data_Valid raised 2 cycles before a tick → accepted on that tick; each bit lasts exactly 4 cycles. DATA_WIDTH=5 build: frame = 7 ticks.
6. Toggle P_DATA/PAR_EN/STOP2 mid-frame → transmitted bits match the values captured at acceptance. Assert RST during data bit 3 → line 1 immediately; a new request after release sends a clean full frame.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional
// even/odd parity, one or two stop bits. Frame format is latched when a word
// is accepted. Bit timing comes from the Baud_En strobe. Back-to-back frames
// leave no idle gap on the line.
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Baud_En,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_Out,
    output logic                  Busy,
    output logic                  Data_Ack
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // State names what the next baud tick will put on the line; the start bit
    // is driven on the acceptance tick itself, so START is only a recovery path.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [1:0]              stop_cnt_r, stop_cnt_s;
    logic [DATA_WIDTH-1:0]   data_r, data_s;
    logic                    par_en_r, par_en_s;
    logic                    par_typ_r, par_typ_s;
    logic                    stop2_r, stop2_s;
    logic                    tx_r, tx_s;
    logic                    busy_r, busy_s;
    logic                    ack_r, ack_s;
    logic                    accept_s;
    logic                    final_stop_s;
    logic [1:0]              nstop_s;

    // Parity over the captured word: even = XOR-reduce, odd = its inverse.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                        input logic odd);
        return (^d) ^ odd;
    endfunction

    // Number of stop bits of the frame in flight, and whether the last one
    // is currently on the line.
    always_comb begin
        nstop_s      = stop2_r ? 2'd2 : 2'd1;
        final_stop_s = (state_r == S_STOP) && (stop_cnt_r == nstop_s);
    end

    // Next-state, line value and handshake for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        stop_cnt_s = stop_cnt_r;
        data_s     = data_r;
        par_en_s   = par_en_r;
        par_typ_s  = par_typ_r;
        stop2_s    = stop2_r;
        tx_s       = tx_r;
        busy_s     = busy_r;
        ack_s      = 1'b0;
        accept_s   = 1'b0;
        if (Baud_En) begin
            case (state_r)
                S_IDLE: begin
                    if (Data_Valid) begin
                        accept_s = 1'b1;
                    end else begin
                        tx_s   = 1'b1;
                        busy_s = 1'b0;
                    end
                end
                S_START: begin
                    state_s = S_DATA;
                    cnt_s   = CNT_ZERO;
                    tx_s    = 1'b0;
                end
                S_DATA: begin
                    tx_s = data_r[cnt_r];
                    if (cnt_r == CNT_LAST) begin
                        cnt_s      = CNT_ZERO;
                        stop_cnt_s = 2'd0;
                        state_s    = par_en_r ? S_PARITY : S_STOP;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    tx_s       = parity_bit(data_r, par_typ_r);
                    stop_cnt_s = 2'd0;
                    state_s    = S_STOP;
                end
                S_STOP: begin
                    if (final_stop_s) begin
                        if (Data_Valid) begin
                            accept_s = 1'b1;
                        end else begin
                            state_s    = S_IDLE;
                            busy_s     = 1'b0;
                            tx_s       = 1'b1;
                            stop_cnt_s = 2'd0;
                        end
                    end else begin
                        tx_s       = 1'b1;
                        stop_cnt_s = stop_cnt_r + 2'd1;
                    end
                end
                default: begin
                    state_s    = S_IDLE;
                    tx_s       = 1'b1;
                    busy_s     = 1'b0;
                    cnt_s      = CNT_ZERO;
                    stop_cnt_s = 2'd0;
                end
            endcase
            if (accept_s) begin
                data_s     = P_DATA;
                par_en_s   = PAR_EN;
                par_typ_s  = PAR_TYP;
                stop2_s    = STOP2;
                tx_s       = 1'b0;
                busy_s     = 1'b1;
                ack_s      = 1'b1;
                state_s    = S_DATA;
                cnt_s      = CNT_ZERO;
                stop_cnt_s = 2'd0;
            end else begin
                ack_s = 1'b0;
            end
        end else begin
            ack_s = 1'b0;
        end
    end

    // Sequencer state, captured frame and registered line outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= S_IDLE;
            cnt_r      <= CNT_ZERO;
            stop_cnt_r <= 2'd0;
            data_r     <= '0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            stop2_r    <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            ack_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            stop_cnt_r <= stop_cnt_s;
            data_r     <= data_s;
            par_en_r   <= par_en_s;
            par_typ_r  <= par_typ_s;
            stop2_r    <= stop2_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
            ack_r      <= ack_s;
        end
    end

    assign TX_Out   = tx_r;
    assign Busy     = busy_r;
    assign Data_Ack = ack_r;

endmodule
